// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch buffer: sequential ROM fetch ahead of the core, {pc, inst} FIFO, flush on redirect.
// Optional same-cycle bypass of an empty FIFO is enabled by defining INST_PREFETCH_BYPASS_EN.
module inst_prefetch_buf #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_inst_o,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_gnt_i,
  input  logic        rom_rvalid_i,
  input  logic [31:0] rom_rdata_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef logic [AW-1:0] ptr_t;

  logic [31:0]   fpc;
  logic [CW-1:0] cnt, inflight, drop;
  logic [31:0]   pc_q [DEPTH];
  ptr_t          pq_wr, pq_rd;
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  ptr_t          wr_ptr, rd_ptr;

  logic [CW:0] credit_sum;
  logic        grant, resp, keep, empty, bypass, push, pop;
  logic [31:0] resp_pc;
  logic        unused_low_bits;

  assign unused_low_bits = ^redirect_pc_i[1:0];

  // In-flight requests plus buffered entries never exceed DEPTH, so pushes always fit.
  assign credit_sum = {1'b0, inflight} + {1'b0, cnt};
  assign rom_req_o  = !rst && !redirect_i && (credit_sum < DEPTH_C);
  assign rom_addr_o = fpc;

  assign grant   = rom_req_o && rom_gnt_i;
  assign resp    = rom_rvalid_i && (inflight != '0);
  assign keep    = resp && (drop == '0) && !redirect_i;
  assign empty   = (cnt == '0);
  assign resp_pc = pc_q[pq_rd];

`ifdef INST_PREFETCH_BYPASS_EN
  assign bypass = keep && empty;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid_o = !redirect_i && (!empty || bypass);
  assign out_pc_o    = !empty ? fifo_pc[rd_ptr]   : (bypass ? resp_pc     : 32'h0);
  assign out_inst_o  = !empty ? fifo_inst[rd_ptr] : (bypass ? rom_rdata_i : 32'h0);

  assign pop  = out_valid_o && out_ready_i && !empty;
  assign push = keep && !(bypass && out_ready_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc      <= RESET_PC;
      cnt      <= '0;
      inflight <= '0;
      drop     <= '0;
      pq_wr    <= '0;
      pq_rd    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= inflight + CW'(grant) - CW'(resp);
      if (grant) pq_wr <= pq_wr + 1'b1;
      if (resp)  pq_rd <= pq_rd + 1'b1;

      if (redirect_i) begin
        fpc    <= {redirect_pc_i[31:2], 2'b00};
        // Everything still owed by the ROM belongs to the old stream, except a response landing now.
        drop   <= inflight - CW'(resp);
        cnt    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (grant) fpc <= fpc + 32'd4;
        if (resp && (drop != '0)) drop <= drop - 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end
  end

  // NOTE: storage arrays carry no reset; the counters and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (grant) pc_q[pq_wr] <= fpc;
    if (push) begin
      fifo_pc[wr_ptr]   <= resp_pc;
      fifo_inst[wr_ptr] <= rom_rdata_i;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Randomized scoreboard bench for inst_prefetch_buf: ROM model, stream-level reference, pop monitor.
// Build with INST_PREFETCH_BYPASS_EN defined to check the bypass variant.
module tb_inst_prefetch_buf;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef INST_PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_pc_o, out_inst_o;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_gnt_i = 1'b0;
  logic        rom_rvalid_i = 1'b0;
  logic [31:0] rom_rdata_i = '0;

  inst_prefetch_buf #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_inst_o(out_inst_o),
    .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o),
    .rom_gnt_i(rom_gnt_i), .rom_rvalid_i(rom_rvalid_i), .rom_rdata_i(rom_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit dead; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } item_t;

  req_t  pending[$];   // requests granted by the ROM model, oldest first
  item_t sb[$];        // instructions the core is still owed, in order

  int n_checks = 0, n_pass = 0;
  int cyc = 0, grants = 0, delivered = 0;
  int p_ready, p_gnt, p_rv, lat_max, p_redir, p_spur;
  bit force_redir = 1'b0;
  logic [31:0] force_pc;
  logic [31:0] exp_fpc = RESET_PC;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(3))
      0:       return $urandom;
      1:       return 32'hFFFF_FFF0 | ($urandom & 32'hF);
      default: return $urandom & 32'h0000_3FFF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
  endtask

  // Drive one cycle of inputs shortly after the rising edge.
  task automatic step(input bit r);
    @(posedge clk);
    #1;
    cyc++;
    rst          = r;
    out_ready_i  = ($urandom_range(99) < p_ready);
    rom_gnt_i    = ($urandom_range(99) < p_gnt);
    rom_rvalid_i = 1'b0;
    rom_rdata_i  = $urandom;
    redirect_i   = 1'b0;
    redirect_pc_i = rand_pc();
    if (!r) begin
      if (force_redir) begin
        redirect_i    = 1'b1;
        redirect_pc_i = force_pc;
        force_redir   = 1'b0;
      end else begin
        redirect_i = ($urandom_range(999) < p_redir);
      end
      if (pending.size() > 0) begin
        if (pending[0].due <= cyc && $urandom_range(99) < p_rv) begin
          rom_rvalid_i = 1'b1;
          rom_rdata_i  = rom_word(pending[0].addr);
        end
      end else if ($urandom_range(99) < p_spur) begin
        rom_rvalid_i = 1'b1;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic cfg(input int rdy, input int gnt, input int rv, input int lat,
                     input int redir, input int spur);
    p_ready = rdy; p_gnt = gnt; p_rv = rv; lat_max = lat; p_redir = redir; p_spur = spur;
  endtask

  // Reference model: updates the expected stream from this cycle's bus events.
  always @(negedge clk) begin
    if (rst) begin
      pending.delete();
      sb.delete();
      exp_fpc = RESET_PC;
      check("rst_valid", 32'(out_valid_o), 32'd0);
      check("rst_req",   32'(rom_req_o),   32'd0);
      check("rst_addr",  rom_addr_o,       RESET_PC);
      check("rst_pc",    out_pc_o,         32'h0);
      check("rst_inst",  out_inst_o,       32'h0);
    end else begin
      bit exp_req, live;
      exp_req = !redirect_i && ((pending.size() + sb.size()) < DEPTH);
      live    = rom_rvalid_i && (pending.size() > 0) && !pending[0].dead;
      check("req",   32'(rom_req_o),   32'(exp_req));
      check("addr",  rom_addr_o,       exp_fpc);
      check("valid", 32'(out_valid_o), 32'(!redirect_i && (sb.size() > 0 || (BYP && live))));
      if (rom_rvalid_i && pending.size() > 0) begin
        req_t r;
        r = pending.pop_front();
        if (!r.dead) sb.push_back('{pc: r.addr, inst: rom_word(r.addr)});
      end
      if (rom_req_o && rom_gnt_i) begin
        pending.push_back('{addr: exp_fpc, due: cyc + 1 + $urandom_range(lat_max), dead: 1'b0});
        exp_fpc = exp_fpc + 32'd4;
        grants++;
      end
      if (redirect_i) begin
        foreach (pending[i]) pending[i].dead = 1'b1;
        sb.delete();
        exp_fpc = {redirect_pc_i[31:2], 2'b00};
      end
    end
  end

  // Monitor: every instruction the core accepts must be the next one owed.
  always @(negedge clk) begin
    #1;
    if (!rst && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        check("spurious_pop", 32'(out_valid_o), 32'd0);
      end else begin
        item_t e;
        e = sb.pop_front();
        check("out_pc",   out_pc_o,   e.pc);
        check("out_inst", out_inst_o, e.inst);
        delivered++;
      end
    end
  end

  initial begin
    int d0, g0;
    cfg(100, 100, 100, 0, 0, 0);
    #1 rst = 1'b1;
    step(1'b1);
    step(1'b1);

    // Back-to-back stream: one delivery per cycle once the pipe fills.
    d0 = delivered;
    run(40);
    check("stream_rate", 32'((delivered - d0) >= 36), 32'd1);

    // Core stall from a clean start: exactly DEPTH grants, then release.
    step(1'b1);
    step(1'b1);
    cfg(0, 100, 100, 0, 0, 0);
    g0 = grants;
    run(10);
    check("stall_grants", 32'(grants - g0), 32'(DEPTH));
    cfg(100, 100, 100, 0, 0, 0);
    run(12);

    // Redirect to an unaligned target with responses outstanding.
    cfg(50, 100, 100, 2, 0, 0);
    run(6);
    force_pc = 32'h0000_0103;
    force_redir = 1'b1;
    run(20);

    // Address wrap at the top of the space.
    cfg(100, 100, 100, 0, 0, 0);
    force_pc = 32'hFFFF_FFF8;
    force_redir = 1'b1;
    run(12);

    // Randomized traffic, including redirects colliding with responses and stray responses.
    cfg(70, 60, 60, 3, 20, 10);
    run(3000);
    cfg(40, 80, 80, 4, 60, 10);
    run(1500);

    // Reset while requests are in flight, then stray responses must be ignored.
    cfg(100, 100, 0, 0, 0, 0);
    run(3);
    step(1'b1);
    step(1'b1);
    cfg(100, 0, 0, 0, 0, 100);
    run(4);
    cfg(100, 100, 100, 1, 0, 0);
    run(12);

    // Drain everything still owed.
    cfg(100, 0, 100, 0, 0, 0);
    run(20);
    check("drain_pending", 32'(pending.size()), 32'd0);
    check("drain_sb",      32'(sb.size()),      32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
